// File: rtl/max7219_writer.sv
// max7219_writer
// Serial display stage for a MAX7219 7-segment controller. After reset it
// sends a fixed five-frame configuration sequence. After that, each update
// strobe sends the six BCD digits (hh:mm:ss) as digit registers 0x01..0x06.
// Each frame is 16 bits, MSB first. The slave samples mosi on the rising
// edge of sclk, and the rising edge of cs latches the frame.
//
// Optional feature: define DP_SEPARATOR_EN to light the decimal points on
// min ones (0x03) and hr ones (0x05). The points toggle on every update that
// is accepted into the snapshot. Without the macro no blink register exists
// and dp is always 0.
//
// Parameters:
//   CLK_DIV    clk cycles per sclk half-period (1..255)
//   INTENSITY  value written to the intensity register (0x0A)
// Ports:
//   clk     system clock, rising edge
//   res     synchronous active-low reset
//   update  single-cycle refresh strobe
//   digits  six BCD nibbles, [3:0] = sec ones ... [23:20] = hr tens
//   sclk    SPI clock, idle low
//   mosi    SPI data, MSB first
//   cs      chip select, active low
//   busy    high while the init or refresh sequence is running
module max7219_writer #(
    parameter int unsigned CLK_DIV   = 2,
    parameter logic [3:0]  INTENSITY = 4'h8
) (
    input  logic        clk,
    input  logic        res,
    input  logic        update,
    input  logic [23:0] digits,
    output logic        sclk,
    output logic        mosi,
    output logic        cs,
    output logic        busy
);

    typedef enum logic [2:0] {RESET_INIT, LOAD, SHIFT_LO, SHIFT_HI, GAP, IDLE} state_t;
    typedef enum logic {SEQ_INIT, SEQ_REFRESH} seq_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      r_state;
    seq_t        r_seq;
    logic [2:0]  r_idx;
    logic [7:0]  r_div;
    logic [3:0]  r_bit;
    logic [15:0] r_shift;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_cs;
    logic        r_busy;
    logic        r_pending;
    logic [23:0] r_snap;
    logic [23:0] r_shadow;

    logic        w_dp;
    logic        w_div_done;
    logic        w_seq_last;
    logic        w_gap_end;
    logic        w_start_init;
    logic        w_start_next;
    logic        w_start_new;
    logic [23:0] w_new_snap;
    logic [15:0] w_load_word;

`ifdef DP_SEPARATOR_EN
    logic r_blink;
    assign w_dp = r_blink;
`else
    assign w_dp = 1'b0;
`endif

    // Frame for entry idx of a sequence: {addr, dp, 3'b000, nibble} for refresh.
    function automatic logic [15:0] frame_word(input seq_t seq, input logic [2:0] idx,
                                               input logic [23:0] snap, input logic dp);
        logic [3:0] nib;
        logic [7:0] addr;
        logic       dp_here;
        nib     = 4'h0;
        addr    = {5'b00000, idx} + 8'd1;
        dp_here = dp && (idx == 3'd2 || idx == 3'd4);
        case (idx)
            3'd0:    nib = snap[3:0];
            3'd1:    nib = snap[7:4];
            3'd2:    nib = snap[11:8];
            3'd3:    nib = snap[15:12];
            3'd4:    nib = snap[19:16];
            default: nib = snap[23:20];
        endcase
        if (seq == SEQ_INIT) begin
            case (idx)
                3'd0:    frame_word = 16'h0C01;
                3'd1:    frame_word = 16'h0F00;
                3'd2:    frame_word = 16'h093F;
                3'd3:    frame_word = 16'h0B05;
                default: frame_word = {12'h0A0, INTENSITY};
            endcase
        end else begin
            frame_word = {addr, dp_here, 3'b000, nib};
        end
    endfunction

    // NOTE: every signal in always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        w_div_done   = (r_div == DIV_LAST);
        w_seq_last   = (r_seq == SEQ_INIT) ? (r_idx == 3'd4) : (r_idx == 3'd5);
        w_gap_end    = (r_state == GAP) && w_div_done;
        w_start_init = (r_state == RESET_INIT);
        w_start_next = w_gap_end && !w_seq_last;
        w_start_new  = (w_gap_end && w_seq_last && r_pending) || (r_state == IDLE && update);
        w_new_snap   = (r_state == IDLE) ? digits : r_shadow;
        // Frame 0 of a refresh is addr 0x01, which never carries dp. So the
        // blink bit toggling in the same cycle cannot affect the word loaded here.
        if (w_start_init)
            w_load_word = frame_word(SEQ_INIT, 3'd0, r_snap, w_dp);
        else if (w_start_new)
            w_load_word = frame_word(SEQ_REFRESH, 3'd0, w_new_snap, w_dp);
        else
            w_load_word = frame_word(r_seq, r_idx + 3'd1, r_snap, w_dp);
    end

    // NOTE: state updates use non-blocking assignments. Later assignments in this
    // block override earlier ones, so a strobe in the same cycle as a pending
    // hand-off re-arms pending.
    always_ff @(posedge clk) begin
        if (!res) begin
            // NOTE: the snapshot and shadow are only 48 flops, so they are reset
            // along with the control state.
            r_state   <= RESET_INIT;
            r_seq     <= SEQ_INIT;
            r_idx     <= 3'd0;
            r_div     <= 8'd0;
            r_bit     <= 4'd0;
            r_shift   <= 16'h0000;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs      <= 1'b1;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
            r_snap    <= 24'h000000;
            r_shadow  <= 24'h000000;
`ifdef DP_SEPARATOR_EN
            r_blink   <= 1'b0;
`endif
        end else begin
            case (r_state)
                LOAD: begin
                    r_state <= SHIFT_LO;
                    r_div   <= 8'd0;
                end
                SHIFT_LO: begin
                    if (w_div_done) begin
                        r_div   <= 8'd0;
                        r_sclk  <= 1'b1;
                        r_state <= SHIFT_HI;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (w_div_done) begin
                        r_div  <= 8'd0;
                        r_sclk <= 1'b0;
                        if (r_bit == 4'd0) begin
                            // cs rises together with the last falling sclk edge.
                            r_cs    <= 1'b1;
                            r_mosi  <= 1'b0;
                            r_state <= GAP;
                        end else begin
                            r_bit   <= r_bit - 4'd1;
                            r_shift <= {r_shift[14:0], 1'b0};
                            r_mosi  <= r_shift[14];
                            r_state <= SHIFT_LO;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                GAP: begin
                    if (!w_div_done)
                        r_div <= r_div + 8'd1;
                    else if (w_seq_last && !r_pending) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: ;
            endcase

            if (w_start_init) begin
                r_seq <= SEQ_INIT;
                r_idx <= 3'd0;
            end
            if (w_start_next)
                r_idx <= r_idx + 3'd1;
            if (w_start_new) begin
                r_seq     <= SEQ_REFRESH;
                r_idx     <= 3'd0;
                r_snap    <= w_new_snap;
                r_busy    <= 1'b1;
                r_pending <= 1'b0;
`ifdef DP_SEPARATOR_EN
                r_blink   <= ~r_blink;
`endif
            end
            if (w_start_init || w_start_next || w_start_new) begin
                r_shift <= w_load_word;
                r_mosi  <= w_load_word[15];
                r_cs    <= 1'b0;
                r_bit   <= 4'd15;
                r_div   <= 8'd0;
                r_state <= LOAD;
            end
            // Any strobe outside IDLE lands in the shadow; the latest one wins.
            if (update && r_state != IDLE) begin
                r_shadow  <= digits;
                r_pending <= 1'b1;
            end
        end
    end

    assign sclk = r_sclk;
    assign mosi = r_mosi;
    assign cs   = r_cs;
    assign busy = r_busy;

endmodule

// File: tb/tb_max7219_writer.sv
// Self-checking bench for max7219_writer (CLK_DIV=2, INTENSITY=4'h8).
// A monitor decodes SPI frames on the falling clk edge and compares each one
// against a queue of expected frames. The main sequence pushes those frames
// when it drives stimulus. The monitor also checks the protocol rules.
module tb_max7219_writer;

    localparam int BUSY_LIMIT = 3000;

    typedef logic [5:0][15:0] frames_t;
    typedef struct packed {
        logic [23:0] digits;
        frames_t     frames;
    } vec_t;

    logic        clk;
    logic        res;
    logic        update;
    logic [23:0] digits;
    logic        sclk;
    logic        mosi;
    logic        cs;
    logic        busy;

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_q[$];
    logic        ignore;
    logic        tb_blink;

    int          mon_edges;
    int          frame_viol;
    int          idle_viol;
    logic [15:0] mon_shift;
    logic        prev_sclk;
    logic        prev_cs;
    logic        hi_mosi;

    max7219_writer #(.CLK_DIV(2), .INTENSITY(4'h8)) dut (
        .clk    (clk),
        .res    (res),
        .update (update),
        .digits (digits),
        .sclk   (sclk),
        .mosi   (mosi),
        .cs     (cs),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic frames_t f6(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                                   input logic [15:0] a3, input logic [15:0] a4, input logic [15:0] a5);
        frames_t r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4; r[5] = a5;
        return r;
    endfunction

    // Queues six refresh frames. With model_dp set, the bench's own blink
    // model adds the decimal points when the separator feature is built in.
    task automatic push_refresh(input frames_t f, input logic model_dp);
        logic [15:0] w;
        if (model_dp) tb_blink = ~tb_blink;
        for (int i = 0; i < 6; i++) begin
            w = f[i];
`ifdef DP_SEPARATOR_EN
            if (model_dp && tb_blink && (i == 2 || i == 4)) w = w | 16'h0080;
`endif
            exp_q.push_back(w);
        end
    endtask

    task automatic push_init();
        exp_q.push_back(16'h0C01);
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h093F);
        exp_q.push_back(16'h0B05);
        exp_q.push_back(16'h0A08);
    endtask

    // Called on a falling edge. Strobes update for one cycle, then checks that
    // busy and LOAD (cs low) appear in the very next cycle.
    task automatic apply_update(input logic [23:0] d);
        digits = d;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        check("busy_rise", busy, 1);
        check("load_cs", cs, 0);
    endtask

    // Counts cycles until busy drops. Strobes may be injected at given counts.
    task automatic measure_busy(input int inj_a, input logic [23:0] dig_a,
                                input int inj_b, input logic [23:0] dig_b, output int n);
        n = 0;
        while (busy === 1'b1 && n < BUSY_LIMIT) begin
            update = 1'b0;
            if (n == inj_a) begin digits = dig_a; update = 1'b1; end
            if (n == inj_b) begin digits = dig_b; update = 1'b1; end
            @(negedge clk);
            n++;
        end
        update = 1'b0;
    endtask

    // SPI monitor and protocol checker.
    initial begin
        mon_edges  = 0;
        frame_viol = 0;
        idle_viol  = 0;
        mon_shift  = 16'h0000;
        prev_sclk  = 1'b0;
        prev_cs    = 1'b1;
        hi_mosi    = 1'b0;
        forever begin
            @(negedge clk);
            if (cs === 1'b1 && sclk === 1'b1) idle_viol++;
            if (cs === 1'b0) begin
                if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                    mon_shift = {mon_shift[14:0], mosi};
                    mon_edges++;
                    hi_mosi = mosi;
                end else if (sclk === 1'b1 && prev_sclk === 1'b1 && mosi !== hi_mosi) begin
                    frame_viol++;
                end
            end
            if (prev_cs === 1'b0 && cs === 1'b1) begin
                if (!ignore) begin
                    check("frame_edges", mon_edges, 16);
                    check("mosi_stable", frame_viol, 0);
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("frame_data", mon_shift, exp_q.pop_front());
                end
                mon_edges  = 0;
                frame_viol = 0;
                mon_shift  = 16'h0000;
            end
            prev_sclk = sclk;
            prev_cs   = cs;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   n;
        int   k;

        vecs[0] = '{24'h235959, f6(16'h0109, 16'h0205, 16'h0309, 16'h0405, 16'h0503, 16'h0602)};
        vecs[1] = '{24'h987654, f6(16'h0104, 16'h0205, 16'h0306, 16'h0407, 16'h0508, 16'h0609)};
        vecs[2] = '{24'h1AF0B7, f6(16'h0107, 16'h020B, 16'h0300, 16'h040F, 16'h050A, 16'h0601)};
        vecs[3] = '{24'h000000, f6(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600)};

        n_checks = 0;
        n_errors = 0;
        ignore   = 1'b0;
        tb_blink = 1'b0;
        res      = 1'b0;
        update   = 1'b0;
        digits   = 24'h000000;

        // Reset state; a strobe during reset must be ignored.
        repeat (3) @(negedge clk);
        digits = 24'h777777;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        check("reset_cs", cs, 1);
        check("reset_sclk", sclk, 0);
        check("reset_mosi", mosi, 0);
        check("reset_busy", busy, 1);

        // Init sequence: 5 frames, busy falls 335 cycles after release.
        push_init();
        res = 1'b1;
        @(negedge clk);
        check("init_load_cs", cs, 0);
        measure_busy(-1, 24'h0, -1, 24'h0, n);
        check("init_busy_cycles", n, 335);
        check("init_drain", exp_q.size(), 0);
        repeat (4) @(negedge clk);

        // Table-driven refreshes from IDLE.
        for (int i = 0; i < 4; i++) begin
            push_refresh(vecs[i].frames, 1'b1);
            apply_update(vecs[i].digits);
            measure_busy(-1, 24'h0, -1, 24'h0, n);
            check("refresh_busy_cycles", n, 402);
            check("refresh_drain", exp_q.size(), 0);
            check("idle_cs", cs, 1);
            repeat (3) @(negedge clk);
        end

        // Two strobes during a refresh: only the latest yields one extra refresh.
        push_refresh(f6(16'h0101, 16'h0201, 16'h0301, 16'h0401, 16'h0501, 16'h0601), 1'b1);
        push_refresh(f6(16'h0101, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600), 1'b1);
        apply_update(24'h111111);
        measure_busy(30, 24'h000000, 100, 24'h000001, n);
        check("pending_busy_cycles", n, 804);
        check("pending_drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        // Reset during the 3rd bit (high phase) of a digit frame.
        ignore = 1'b1;
        apply_update(24'h654321);
        k = 0;
        while (mon_edges < 2 && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("abort_reach_bit", mon_edges, 2);
        repeat (4) @(negedge clk);
        check("pre_abort_sclk", sclk, 1);
        res = 1'b0;
        @(negedge clk);
        check("abort_cs", cs, 1);
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 1);
        res = 1'b1;
        @(posedge clk);
        ignore   = 1'b0;
        tb_blink = 1'b0;

        // Init replays; a strobe during init becomes a pending refresh of 12:00:00.
        push_init();
`ifdef DP_SEPARATOR_EN
        push_refresh(f6(16'h0100, 16'h0200, 16'h0380, 16'h0400, 16'h0582, 16'h0601), 1'b0);
`else
        push_refresh(f6(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0502, 16'h0601), 1'b0);
`endif
        @(negedge clk);
        check("reinit_load_cs", cs, 0);
        measure_busy(20, 24'h120000, -1, 24'h0, n);
        check("reinit_pending_busy_cycles", n, 737);
        check("reinit_drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        // Second consecutive refresh of 12:00:00: the decimal points toggle off.
        push_refresh(f6(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0502, 16'h0601), 1'b0);
        apply_update(24'h120000);
        measure_busy(-1, 24'h0, -1, 24'h0, n);
        check("dp_busy_cycles", n, 402);
        repeat (3) @(negedge clk);

        check("sb_empty", exp_q.size(), 0);
        check("idle_sclk_viol", idle_viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/max7219_writer.md
# max7219_writer

Serial display stage downstream of the time-of-day counter chain. Takes the six BCD digits (hh:mm:ss) produced by the counters and drives an external MAX7219 7-segment controller over a write-only SPI link. After reset it sends a fixed configuration sequence. On each update strobe it sends the six digit registers.

## Interface
Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range 1..255
- INTENSITY, 4'h8: value written to the MAX7219 intensity register (0x0A)

Ports:
- clk  input  1  system clock; all logic on rising edge
- res  input  1  reset; synchronous, active-low
- update  input  1  single-cycle strobe requesting a display refresh
- digits  input  24  BCD: [3:0] sec ones, [7:4] sec tens, [11:8] min ones, [15:12] min tens, [19:16] hr ones, [23:20] hr tens
- sclk  output  1  SPI clock, idle low; MAX7219 samples on rising edge
- mosi  output  1  SPI data, MSB first
- cs  output  1  chip select, active low; rising edge latches the frame
- busy  output  1  high while the init or refresh sequence is running

## Operation
- Frame: 16 bits, {8'h00 | addr[7:0], data[7:0]}, where the upper address nibble is 0; bit 15 is sent first.
- States: RESET_INIT, LOAD, SHIFT_LO, SHIFT_HI, GAP, IDLE.
- Reset (res=0): cs=1, sclk=0, mosi=0, busy=1, pending=0, frame index=0, sequence=INIT.
- INIT sequence, 5 frames in this order: 0x0C01 (normal operation), 0x0F00 (display test off), 0x093F (BCD decode on digits 0-5), 0x0B05 (scan limit 6 digits), 0x0A0{INTENSITY}.
- After the INIT sequence: IDLE, busy=0.
- REFRESH sequence, 6 frames, addr 0x01..0x06. Data = {dp, 3'b000, bcd}. addr 0x01 carries sec ones, and each following address carries the next nibble of the snapshot, ending with 0x06 = hr tens.
- update while in IDLE:
  - digits are copied to a snapshot register.
  - REFRESH starts on the next cycle; busy=1.
- update while busy:
  - digits are copied to a shadow register; pending=1.
  - Further updates overwrite the shadow (the latest value wins).
- End of any sequence with pending=1:
  - shadow is copied to the snapshot; pending clears.
  - REFRESH starts immediately; busy stays high.
- update is ignored while res=0. Strobes arriving during INIT are captured as pending.
- Non-BCD nibbles (>9) are sent unchanged; the MAX7219 displays its own glyphs for them.
- res=0 mid-frame: within one cycle cs=1 and sclk=0. The frame is abandoned and the INIT sequence restarts after res releases.

## Timing
- LOAD, 1 cycle: cs falls, mosi = bit15, sclk=0.
- Each bit:
  - SHIFT_LO holds sclk=0 for CLK_DIV cycles.
  - SHIFT_HI holds sclk=1 for CLK_DIV cycles.
  - mosi changes only on the cycle sclk falls, giving a full half-period of setup and of hold.
- After the high phase of bit 0: sclk=0 and cs rises in the same cycle. GAP then holds cs=1 for CLK_DIV cycles before the next LOAD.
- Frame cost: 1 + 2·16·CLK_DIV + CLK_DIV cycles. With CLK_DIV=2 this is 67 cycles.
- First LOAD of INIT occurs on the first cycle after res returns high.
- update seen at cycle N in IDLE: LOAD at N+1; busy rises at N+1.
- busy falls on the cycle after the final GAP completes, unless pending=1.
- sclk is held low whenever cs=1.

## Configuration
- DP_SEPARATOR_EN defined:
  - A blink bit toggles on every update that is accepted into the snapshot. It is reset to 0.
  - dp = blink bit on addr 0x03 (min ones) and addr 0x05 (hr ones).
- Not defined: dp=0 on all digits; no blink register is synthesized.

## Test plan
- Reset release, CLK_DIV=2, INTENSITY=4'h8 -> 5 SPI frames decode as 0x0C01, 0x0F00, 0x093F, 0x0B05, 0x0A08; busy falls exactly 335 cycles after release.
- After init, update with digits=24'h235959 -> 6 frames decode as 0x0109, 0x0205, 0x0309, 0x0405, 0x0503, 0x0602; busy high for 402 cycles.
- Two updates during a refresh, 24'h000000 then 24'h000001 -> exactly one extra refresh follows with no gap in busy; its first frame is 0x0101.
- res=0 for 1 cycle during the 3rd bit of a digit frame -> cs=1 and sclk=0 on the next cycle; the full init sequence replays.
- With DP_SEPARATOR_EN, two consecutive refreshes of 24'h120000 -> addr 0x03 carries 0x80 then 0x00, and addr 0x05 carries 0x82 then 0x02; without the macro both refreshes carry 0x00 and 0x02.
- Protocol checker over all tests -> mosi is stable while sclk=1, every frame has exactly 16 rising edges, and sclk=0 whenever cs=1.
